// File: rtl/div_result_buffer.sv
// ---------------------------------------------------------------------------
// div_result_buffer
//
// Completion buffer that sits right after the pipelined divider. The divider
// cannot stall, so every completion is captured in a small FIFO and offered to
// the CDB arbiter. A credit scheme (in-flight ops + buffered entries <= DEPTH)
// guarantees room for every completion in legal use. On a pipeline flush the
// FIFO is emptied and every op still inside the divider is remembered in
// drop_cnt so its completion is thrown away when it eventually arrives.
//
// Handshakes:
//   cdb_valid/cdb_grant : the head entry is offered while cdb_valid=1 and is
//                         consumed on a cycle where cdb_valid && cdb_grant.
//                         cdb_grant with cdb_valid=0 has no effect.
//   div_issue/issue_ready: a divide may start only in a cycle where
//                         issue_ready=1; issue_ready depends on registers only.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   div_issue                  divider start pulse
//   flush                      drop buffered and in-flight results
//   div_done, div_result, div_exception, div_tag, div_pc
//                              divider completion
//   issue_ready                a new divide may start this cycle
//   cdb_valid, cdb_data, cdb_tag, cdb_pc, cdb_exception
//                              head entry (all zero when the FIFO is empty)
//   cdb_grant                  arbiter accepts head this cycle
//   occupancy                  number of buffered entries
//   overflow_err               sticky protocol-violation flag
// ---------------------------------------------------------------------------
module div_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int PREG_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       div_issue,
  input  logic                       flush,
  input  logic                       div_done,
  input  logic [XLEN-1:0]            div_result,
  input  logic                       div_exception,
  input  logic [PREG_W-1:0]          div_tag,
  input  logic [XLEN-1:0]            div_pc,
  output logic                       issue_ready,
  output logic                       cdb_valid,
  output logic [XLEN-1:0]            cdb_data,
  output logic [PREG_W-1:0]          cdb_tag,
  output logic [XLEN-1:0]            cdb_pc,
  output logic                       cdb_exception,
  input  logic                       cdb_grant,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = XLEN + PREG_W + XLEN + 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  // Entry layout: {result, tag, pc, exception}
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credits_used;

  logic            full;
  logic            do_pop;
  logic            do_push;
  logic            do_drop;
  logic            push_full;
  logic            inc_out;
  logic            dec_out;
  logic            err_issue;
  logic            err_done;

  assign full         = (count == DEPTH_C);
  assign credits_used = {1'b0, count} + {1'b0, outstanding};
  assign issue_ready  = (credits_used < DEPTH_WIDE);

  always_comb begin
    do_pop    = 1'b0;
    do_drop   = 1'b0;
    do_push   = 1'b0;
    push_full = 1'b0;
    inc_out   = 1'b0;
    dec_out   = 1'b0;
    err_issue = 1'b0;
    err_done  = 1'b0;

    do_pop    = cdb_valid && cdb_grant && !flush;
    do_drop   = div_done && !flush && (drop_cnt != '0);
    // A push into a full FIFO is only legal when the head leaves the same
    // cycle; the slot being freed is the one written (wr_ptr == rd_ptr).
    do_push   = div_done && !flush && (drop_cnt == '0) && (!full || do_pop);
    push_full = div_done && !flush && (drop_cnt == '0) && full && !do_pop;
    inc_out   = div_issue && !flush;
    // Saturate at zero so a spurious completion cannot wrap the counter.
    dec_out   = div_done && (outstanding != '0);
    err_issue = inc_out && !issue_ready;
    err_done  = div_done && (outstanding == '0);
  end

  // Storage has no reset: the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= {div_result, div_tag, div_pc, div_exception};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // Everything still in the divider after this cycle will be discarded.
      outstanding <= outstanding - CW'(dec_out);
      drop_cnt    <= outstanding - CW'(dec_out);
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
      outstanding <= outstanding + CW'(inc_out) - CW'(dec_out);
      if (do_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (err_issue || push_full || err_done) begin
      overflow_err <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign cdb_valid     = (count != '0);
  assign occupancy     = count;
  assign cdb_data      = cdb_valid ? head[EW-1 -: XLEN]              : '0;
  assign cdb_tag       = cdb_valid ? head[XLEN+PREG_W : XLEN+1]      : '0;
  assign cdb_pc        = cdb_valid ? head[XLEN : 1]                  : '0;
  assign cdb_exception = cdb_valid ? head[0]                         : 1'b0;

endmodule

// File: tb/tb_div_result_buffer.sv
module tb_div_result_buffer;

  localparam int DEPTH  = 4;
  localparam int XLEN   = 32;
  localparam int PREG_W = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              div_issue;
  logic              flush;
  logic              div_done;
  logic [XLEN-1:0]   div_result;
  logic              div_exception;
  logic [PREG_W-1:0] div_tag;
  logic [XLEN-1:0]   div_pc;
  logic              issue_ready;
  logic              cdb_valid;
  logic [XLEN-1:0]   cdb_data;
  logic [PREG_W-1:0] cdb_tag;
  logic [XLEN-1:0]   cdb_pc;
  logic              cdb_exception;
  logic              cdb_grant;
  logic [CW-1:0]     occupancy;
  logic              overflow_err;

  div_result_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .div_issue(div_issue), .flush(flush),
    .div_done(div_done), .div_result(div_result), .div_exception(div_exception),
    .div_tag(div_tag), .div_pc(div_pc), .issue_ready(issue_ready),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .cdb_pc(cdb_pc), .cdb_exception(cdb_exception), .cdb_grant(cdb_grant),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [XLEN-1:0]   d;
    logic [PREG_W-1:0] t;
    logic [XLEN-1:0]   p;
    logic              x;
  } ent_t;

  ent_t exp_q[$];   // results waiting for the arbiter, oldest first
  int   m_out;      // ops inside the divider that will complete
  int   m_drop;     // of those, how many were killed by a flush
  logic m_err;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic m_ready();
    return (exp_q.size() + m_out) < DEPTH;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic pop;
    ent_t ent;
    if (div_done && m_out == 0) m_err = 1'b1;
    if (div_issue && !flush && !m_ready()) m_err = 1'b1;
    if (flush) begin
      exp_q.delete();
      if (div_done && m_out > 0) m_out--;
      m_drop = m_out;
    end else begin
      pop = cdb_grant && (exp_q.size() > 0);
      if (div_done && m_drop > 0) begin
        m_drop--;
      end else if (div_done) begin
        if (exp_q.size() == DEPTH && !pop) begin
          m_err = 1'b1;
        end else begin
          if (pop) begin
            void'(exp_q.pop_front());
            pop = 1'b0;
          end
          ent.d = div_result; ent.t = div_tag; ent.p = div_pc; ent.x = div_exception;
          exp_q.push_back(ent);
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (div_done && m_out > 0) m_out--;
      if (div_issue) m_out++;
    end
  endtask

  task automatic check_all(input string name);
    ent_t hd;
    logic v;
    v  = (exp_q.size() > 0);
    hd = v ? exp_q[0] : '0;
    check({name, ".valid"},     64'(cdb_valid),     64'(v));
    check({name, ".data"},      64'(cdb_data),      64'(hd.d));
    check({name, ".tag"},       64'(cdb_tag),       64'(hd.t));
    check({name, ".pc"},        64'(cdb_pc),        64'(hd.p));
    check({name, ".exception"}, 64'(cdb_exception), 64'(hd.x));
    check({name, ".occupancy"}, 64'(occupancy),     64'(exp_q.size()));
    check({name, ".ready"},     64'(issue_ready),   64'(m_ready()));
    check({name, ".err"},       64'(overflow_err),  64'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input string name, input logic iss, input logic fl, input logic dn,
                     input logic [XLEN-1:0] res, input logic [PREG_W-1:0] tg,
                     input logic [XLEN-1:0] pc, input logic exc, input logic gr);
    div_issue = iss; flush = fl; div_done = dn; div_result = res;
    div_tag = tg; div_pc = pc; div_exception = exc; cdb_grant = gr;
    model_step();
    @(posedge clk);
    #1;
    check_all(name);
  endtask

  task automatic idle(input string name);
    cyc(name, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    div_issue = 0; flush = 0; div_done = 0; div_result = '0;
    div_tag = '0; div_pc = '0; div_exception = 0; cdb_grant = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_out = 0; m_drop = 0; m_err = 1'b0;
    check_all("reset");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            iss, fl, dn, gr, exc;
    logic [XLEN-1:0] res;
    logic [7:0]      tg;
    logic [XLEN-1:0] pc;
    logic            e_valid;
    logic [XLEN-1:0] e_data;
    int              e_occ;
    logic            e_ready;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic iss, input logic dn, input logic gr,
                              input logic [XLEN-1:0] res, input logic [7:0] tg,
                              input logic [XLEN-1:0] pc, input logic ev,
                              input logic [XLEN-1:0] ed, input int eo, input logic er);
    vec_t v;
    v.iss = iss; v.fl = 1'b0; v.dn = dn; v.gr = gr; v.exc = 1'b0;
    v.res = res; v.tg = tg; v.pc = pc;
    v.e_valid = ev; v.e_data = ed; v.e_occ = eo; v.e_ready = er;
    return v;
  endfunction

  initial begin
    // single op round trip, then fill all credits and the FIFO
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0,      0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 7, 8'h12, 32'h100, 1, 7, 1, 1);
    tbl[2]  = mk(0, 0, 1, 0, 8'h00, 0,      0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 8'h00, 0,      0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 8'h00, 0,      0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 8'h00, 0,      0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 8'h00, 0,      0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 8'h21, 32'h204, 1, 1, 1, 0);
    tbl[8]  = mk(0, 1, 0, 2, 8'h22, 32'h208, 1, 1, 2, 0);
    tbl[9]  = mk(0, 1, 0, 3, 8'h23, 32'h20c, 1, 1, 3, 0);
    tbl[10] = mk(0, 1, 0, 4, 8'h24, 32'h210, 1, 1, 4, 0);
    tbl[11] = mk(0, 0, 1, 0, 8'h00, 0,      1, 2, 3, 1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic iss, dn, fl, gr;
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].iss, tbl[i].fl, tbl[i].dn, tbl[i].res,
          tbl[i].tg, tbl[i].pc, tbl[i].exc, tbl[i].gr);
      check($sformatf("tbl%0d.v", i),   64'(cdb_valid),   64'(tbl[i].e_valid));
      check($sformatf("tbl%0d.d", i),   64'(cdb_data),    64'(tbl[i].e_data));
      check($sformatf("tbl%0d.occ", i), 64'(occupancy),   64'(tbl[i].e_occ));
      check($sformatf("tbl%0d.rdy", i), 64'(issue_ready), 64'(tbl[i].e_ready));
    end

    // Full FIFO with completion and grant together. With DEPTH credits a
    // completion can only meet a full FIFO after an over-credit issue, so
    // overflow_err is set by that issue, not by the push.
    cyc("full_a", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("full_b", 0, 0, 1, 5, 8'h25, 32'h214, 0, 0);
    check("full_occ4", 64'(occupancy), 64'd4);
    cyc("full_c", 1, 0, 0, 0, 0, 0, 0, 0);
    check("full_err_issue", 64'(overflow_err), 64'd1);
    cyc("full_d", 0, 0, 1, 6, 8'h26, 32'h218, 0, 1);
    check("full_pushpop_occ", 64'(occupancy), 64'd4);
    check("full_pushpop_head", 64'(cdb_data), 64'd3);
    for (int k = 4; k <= 6; k++) begin
      cyc("full_drain", 0, 0, 0, 0, 0, 0, 0, 1);
      check($sformatf("full_order%0d", k), 64'(cdb_data), 64'(k));
    end
    cyc("full_last", 0, 0, 0, 0, 0, 0, 0, 1);
    check("full_empty", 64'(cdb_valid), 64'd0);

    // Flush with two buffered and two in flight.
    do_reset();
    cyc("fl_i1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_i2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_i3", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_d1", 0, 0, 1, 32'h11, 8'h01, 32'h300, 0, 0);
    cyc("fl_d2", 0, 0, 1, 32'h22, 8'h02, 32'h304, 0, 0);
    cyc("fl_i4", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_flush", 1, 1, 0, 0, 0, 0, 0, 1);
    check("fl_occ0", 64'(occupancy), 64'd0);
    check("fl_valid0", 64'(cdb_valid), 64'd0);
    cyc("fl_drop1", 0, 0, 1, 32'h33, 8'h03, 32'h308, 0, 0);
    cyc("fl_drop2", 0, 0, 1, 32'h44, 8'h04, 32'h30c, 0, 0);
    check("fl_dropped", 64'(occupancy), 64'd0);
    cyc("fl_new_i", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_new_d", 0, 0, 1, 32'h55, 8'h05, 32'h310, 0, 0);
    check("fl_new_data", 64'(cdb_data), 64'h55);
    // completion in the flush cycle itself is discarded and not counted again
    cyc("fl2_i", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl2_flush", 0, 1, 1, 32'h66, 8'h06, 32'h314, 0, 0);
    cyc("fl2_i2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl2_d2", 0, 0, 1, 32'h77, 8'h07, 32'h318, 0, 0);
    check("fl2_data", 64'(cdb_data), 64'h77);
    check("fl2_err", 64'(overflow_err), 64'd0);

    // Exception flag travels with its own entry only.
    do_reset();
    cyc("ex_i1", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ex_i2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ex_d1", 0, 0, 1, 0, 8'h09, 32'h400, 1, 0);
    cyc("ex_d2", 0, 0, 1, 9, 8'h0a, 32'h404, 0, 0);
    check("ex_head_exc", 64'(cdb_exception), 64'd1);
    check("ex_head_data", 64'(cdb_data), 64'd0);
    cyc("ex_pop", 0, 0, 0, 0, 0, 0, 0, 1);
    check("ex_next_exc", 64'(cdb_exception), 64'd0);
    check("ex_next_data", 64'(cdb_data), 64'd9);

    // Over-credit issue sets a sticky error cleared only by reset.
    do_reset();
    for (int k = 0; k < 4; k++) cyc("st_i", 1, 0, 0, 0, 0, 0, 0, 0);
    check("st_ready0", 64'(issue_ready), 64'd0);
    cyc("st_bad", 1, 0, 0, 0, 0, 0, 0, 0);
    check("st_err1", 64'(overflow_err), 64'd1);
    cyc("st_flush", 0, 1, 0, 0, 0, 0, 0, 0);
    idle("st_idle1");
    idle("st_idle2");
    check("st_err_sticky", 64'(overflow_err), 64'd1);
    do_reset();
    check("st_err_cleared", 64'(overflow_err), 64'd0);

    // Randomized legal traffic against the model.
    for (int n = 0; n < 800; n++) begin
      fl  = ($urandom_range(0, 39) == 0);
      iss = m_ready() && ($urandom_range(0, 1) == 1);
      dn  = (m_out > 0) && ($urandom_range(0, 2) != 0);
      gr  = ($urandom_range(0, 3) != 0);
      cyc("rand", iss, fl, dn, $urandom, PREG_W'($urandom), $urandom,
          ($urandom_range(0, 7) == 0), gr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
